game_param_regs: RTL and testbench
==================================

Name: game_param_regs

Overview:
Runtime-adjustable successor to the fixed game-constant block. It holds the four Pong geometry parameters (ball radius, paddle width, paddle half-height, padding) in registers loaded with defaults at reset. Players edit the parameters from the board buttons while the game is not running, with saturation at per-parameter limits and auto-repeat on held buttons. Outputs feed the ball, paddle and renderer modules directly.

Parameters:
WIDTH, 8, bit width of every parameter output
REPEAT_DELAY, 25000000, cycles a button must be held before auto-repeat starts
REPEAT_RATE, 5000000, cycles between auto-repeat steps

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
btn_sel  in  1  active-high, already synchronised; advance the selected parameter
btn_up  in  1  active-high, already synchronised; increment the selected parameter
btn_down  in  1  active-high, already synchronised; decrement the selected parameter
restore_defaults  in  1  active-high level; reload all defaults
game_running  in  1  high locks all parameters
ball_radius  out  WIDTH  current ball radius
paddle_width  out  WIDTH  current paddle width
paddle_height  out  WIDTH  current distance from paddle centre to paddle edge
padding  out  WIDTH  current screen-edge padding
sel_idx  out  2  selected parameter: 0 ball_radius, 1 paddle_width, 2 paddle_height, 3 padding
edit_active  out  1  high when game_running=0
param_changed  out  1  one-cycle pulse when any parameter value actually changes

Behaviour:
- Reset (rst_n=0 at a clk edge): outputs take 5 / 10 / 50 / 16; sel_idx=0; param_changed=0; FSM goes to IDLE; button history registers cleared.
- Reset mid-repeat aborts the repeat. No step is applied on the reset edge.
- Button edges: each button has a registered previous sample. A rise is btn & ~prev.
- Latency: an output changes on the first clk edge at which the rise is seen, so it is visible one cycle after the button goes high.
- btn_sel rise: sel_idx increments and wraps from 3 to 0. btn_sel is ignored while btn_up or btn_down is held.
- Limits (min..max): ball_radius 1..15, paddle_width 2..40, paddle_height 10..120, padding 0..64.
- Steps saturate at the limit. A saturated step produces no param_changed pulse. Arithmetic is done in WIDTH+1 bits before clamping.
- FSM states:
  - LOCKED: entered whenever game_running=1, from any state, on the same edge. No edits or selection.
  - IDLE: waits for a rise on up or down.
  - DELAY: the first step is applied on the entry edge. A counter runs for REPEAT_DELAY cycles.
  - REPEAT: one step every REPEAT_RATE cycles while the button stays held.
- Transitions:
  - LOCKED -> IDLE when game_running=0.
  - DELAY or REPEAT -> IDLE when the active button is released.
  - The direction is latched on entry to DELAY. A press of the other button during DELAY or REPEAT is ignored until return to IDLE.
- Simultaneous up and down rise in IDLE: no step; stay in IDLE.
- restore_defaults=1: reload defaults on that edge and pulse param_changed if any value differed. It is honoured even in LOCKED and has priority over any step. The FSM returns to IDLE, or stays in LOCKED if game_running=1. sel_idx is unchanged.
- edit_active = ~game_running, registered, reset value 1.

Optional Feature:
PARAM_AUTOREPEAT_EN
- Defined: the DELAY/REPEAT auto-repeat behaviour described above.
- Undefined: exactly one step per rise. The FSM reduces to LOCKED/IDLE/HELD, and HELD returns to IDLE on release. Repeat counters are not synthesised. The REPEAT_* parameters are accepted but unused.

Decomposition:
- Shared include game_params_defs.vh holds:
  - index localparams IDX_BALL_RADIUS, IDX_PADDLE_WIDTH, IDX_PADDLE_HEIGHT, IDX_PADDING
  - DEF_*, MIN_* and MAX_* constants per parameter
  - FSM state encodings
- One natural sub-module, hold_repeat: edge detection, direction latch, DELAY/REPEAT counter and step-pulse output. The parent keeps the register file, clamp and selection.

Test Plan (bench runs REPEAT_DELAY=4, REPEAT_RATE=2):
- Reset then release -> outputs 5/10/50/16, sel_idx=0, param_changed=0.
- sel_idx=0, btn_up pulsed 1 cycle -> ball_radius=6 one cycle later; single param_changed pulse.
- sel_idx=2, btn_up held 12 cycles -> paddle_height steps 51 immediately, then +1 at hold cycles 5, 7, 9, 11 (value 55). Without PARAM_AUTOREPEAT_EN, value stays 51.
- ball_radius=15, btn_up pressed -> stays 15, no param_changed. padding=0, btn_down pressed -> stays 0.
- btn_sel pressed 4 times from 0 -> sel_idx 1, 2, 3, 0. game_running=1 during a held btn_up -> no further steps, edit_active=0.
- paddle_width=20 and restore_defaults=1 coincident with a btn_up rise -> paddle_width=10, one param_changed pulse.

Source files
------------

// File: rtl/game_param_regs_pkg.sv
// game_param_regs_pkg: shared constants for the runtime Pong parameter registers
//   IDX_*            register-file slot of each parameter (also the sel_idx value)
//   DEF_*/MIN_*/MAX_* reset default and saturation limits per parameter
//   state_e          edit FSM encodings (DELAY/REPEAT used with PARAM_AUTOREPEAT_EN, HELD without)
package game_param_regs_pkg;
   localparam int IDX_BALL_RADIUS   = 0;
   localparam int IDX_PADDLE_WIDTH  = 1;
   localparam int IDX_PADDLE_HEIGHT = 2;
   localparam int IDX_PADDING       = 3;
   localparam int DEF_BALL_RADIUS   = 5;
   localparam int DEF_PADDLE_WIDTH  = 10;
   localparam int DEF_PADDLE_HEIGHT = 50;
   localparam int DEF_PADDING       = 16;
   localparam int MIN_BALL_RADIUS   = 1;
   localparam int MIN_PADDLE_WIDTH  = 2;
   localparam int MIN_PADDLE_HEIGHT = 10;
   localparam int MIN_PADDING       = 0;
   localparam int MAX_BALL_RADIUS   = 15;
   localparam int MAX_PADDLE_WIDTH  = 40;
   localparam int MAX_PADDLE_HEIGHT = 120;
   localparam int MAX_PADDING       = 64;
   localparam int DEF_VAL [4] = '{DEF_BALL_RADIUS, DEF_PADDLE_WIDTH, DEF_PADDLE_HEIGHT, DEF_PADDING};
   localparam int MIN_VAL [4] = '{MIN_BALL_RADIUS, MIN_PADDLE_WIDTH, MIN_PADDLE_HEIGHT, MIN_PADDING};
   localparam int MAX_VAL [4] = '{MAX_BALL_RADIUS, MAX_PADDLE_WIDTH, MAX_PADDLE_HEIGHT, MAX_PADDING};
   typedef enum logic [2:0] {
      ST_LOCKED = 3'd0,
      ST_IDLE   = 3'd1,
      ST_DELAY  = 3'd2,
      ST_REPEAT = 3'd3,
      ST_HELD   = 3'd4
   } state_e;
endpackage

// File: rtl/game_param_regs_if.sv
// game_param_regs_if: button inputs and parameter outputs of game_param_regs
//   slave  (design side): buttons/restore/game_running in, parameters/sel/status out
//   master (driver side): the mirror image
interface game_param_regs_if #(parameter int WIDTH = 8);
   logic             btn_sel;
   logic             btn_up;
   logic             btn_down;
   logic             restore_defaults;
   logic             game_running;
   logic [WIDTH-1:0] ball_radius;
   logic [WIDTH-1:0] paddle_width;
   logic [WIDTH-1:0] paddle_height;
   logic [WIDTH-1:0] padding;
   logic [1:0]       sel_idx;
   logic             edit_active;
   logic             param_changed;
   modport slave (
      input  btn_sel, btn_up, btn_down, restore_defaults, game_running,
      output ball_radius, paddle_width, paddle_height, padding, sel_idx, edit_active, param_changed
   );
   modport master (
      output btn_sel, btn_up, btn_down, restore_defaults, game_running,
      input  ball_radius, paddle_width, paddle_height, padding, sel_idx, edit_active, param_changed
   );
endinterface

// File: rtl/game_param_regs_hold_repeat.sv
// game_param_regs_hold_repeat: up/down edge detection, direction latch and step pulse generation
//   clk, rst_n        clock, synchronous active-low reset
//   game_running_i    forces LOCKED and suppresses steps
//   restore_i         aborts any hold and suppresses steps
//   btn_up_i/down_i   synchronised buttons
//   step_o            apply one step at the coming edge
//   dir_up_o          direction of that step (1 = increment)
// Macro PARAM_AUTOREPEAT_EN: when defined a held button repeats after REPEAT_DELAY
// cycles every REPEAT_RATE cycles; otherwise one step per press.
module game_param_regs_hold_repeat
   import game_param_regs_pkg::*;
#(
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic game_running_i,
   input  logic restore_i,
   input  logic btn_up_i,
   input  logic btn_down_i,
   output logic step_o,
   output logic dir_up_o
);
   state_e state_q, state_d;
   logic   up_prev_q, dn_prev_q, dir_q, dir_d;
   logic   rise_up, rise_dn, held, busy, last;
   assign rise_up = btn_up_i & ~up_prev_q;
   assign rise_dn = btn_down_i & ~dn_prev_q;
   // only the latched button matters once a hold has started
   assign held    = dir_q ? btn_up_i : btn_down_i;
   assign busy    = state_q inside {ST_DELAY, ST_REPEAT, ST_HELD};
`ifdef PARAM_AUTOREPEAT_EN
   localparam state_e ST_FIRST = ST_DELAY;
   localparam int     CMAX     = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
   localparam int     CW       = $clog2(CMAX + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   // one counter serves both the initial delay and the repeat period
   assign last = cnt_q == (state_q == ST_DELAY ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_RATE - 1));
   always_comb cnt_d = (state_q inside {ST_DELAY, ST_REPEAT}) && held && !last && !game_running_i && !restore_i
      ? cnt_q + 1'b1 : '0;
   always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
`else
   localparam state_e ST_FIRST = ST_HELD;
   assign last = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         up_prev_q <= 1'b0;
         dn_prev_q <= 1'b0;
         dir_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         up_prev_q <= btn_up_i;
         dn_prev_q <= btn_down_i;
         dir_q     <= dir_d;
      end
   end
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      if (game_running_i) state_d = ST_LOCKED;
      else if (restore_i || state_q == ST_LOCKED) state_d = ST_IDLE;
      else if (state_q == ST_IDLE) begin
         if (rise_up ^ rise_dn) begin
            state_d = ST_FIRST;
            dir_d   = rise_up;
         end
      end else if (!held) state_d = ST_IDLE;
      else if (last) state_d = ST_REPEAT;
   end
   always_comb begin
      step_o   = !game_running_i && !restore_i &&
                 (state_q == ST_IDLE ? (rise_up ^ rise_dn) : (busy && held && last));
      dir_up_o = state_q == ST_IDLE ? rise_up : dir_q;
   end
endmodule

// File: rtl/game_param_regs.sv
// game_param_regs: runtime-editable Pong geometry parameters with saturation
//   clk, rst_n  clock, synchronous active-low reset
//   bus.slave   buttons, restore_defaults, game_running in;
//               ball_radius, paddle_width, paddle_height, padding, sel_idx,
//               edit_active, param_changed out
// Macro PARAM_AUTOREPEAT_EN enables auto-repeat of held up/down buttons.
module game_param_regs
   import game_param_regs_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000
) (
   input logic              clk,
   input logic              rst_n,
   game_param_regs_if.slave bus
);
   logic [3:0][WIDTH-1:0] par_q, par_d, dflt;
   logic [1:0]            sel_q, sel_d;
   logic                  sel_prev_q, edit_q, changed_q, sel_en, step, dir_up;
   logic [WIDTH:0]        ext, up_v, dn_v, lo, hi;
   logic [WIDTH-1:0]      nxt;
   game_param_regs_hold_repeat #(
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
   ) u_hold (
      .clk           (clk),
      .rst_n         (rst_n),
      .game_running_i(bus.game_running),
      .restore_i     (bus.restore_defaults),
      .btn_up_i      (bus.btn_up),
      .btn_down_i    (bus.btn_down),
      .step_o        (step),
      .dir_up_o      (dir_up)
   );
   always_comb for (int i = 0; i < 4; i++) dflt[i] = WIDTH'(DEF_VAL[i]);
   // one extra bit keeps 0-1 and MAX+1 visible for clamping
   always_comb begin
      ext  = {1'b0, par_q[sel_q]};
      up_v = ext + 1'b1;
      dn_v = ext - 1'b1;
      lo   = (WIDTH+1)'(MIN_VAL[sel_q]);
      hi   = (WIDTH+1)'(MAX_VAL[sel_q]);
      nxt  = dir_up ? (up_v > hi ? hi[WIDTH-1:0] : up_v[WIDTH-1:0])
                    : (dn_v[WIDTH] || dn_v < lo ? lo[WIDTH-1:0] : dn_v[WIDTH-1:0]);
      par_d = par_q;
      if (bus.restore_defaults) par_d = dflt;
      else if (step) par_d[sel_q] = nxt;
      sel_en = bus.btn_sel && !sel_prev_q && !bus.btn_up && !bus.btn_down &&
               !bus.game_running && !bus.restore_defaults;
      sel_d  = sel_q + {1'b0, sel_en};
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_q      <= dflt;
         sel_q      <= '0;
         sel_prev_q <= 1'b0;
         edit_q     <= 1'b1;
         changed_q  <= 1'b0;
      end else begin
         par_q      <= par_d;
         sel_q      <= sel_d;
         sel_prev_q <= bus.btn_sel;
         edit_q     <= ~bus.game_running;
         changed_q  <= par_d != par_q;
      end
   end
   assign bus.ball_radius   = par_q[IDX_BALL_RADIUS];
   assign bus.paddle_width  = par_q[IDX_PADDLE_WIDTH];
   assign bus.paddle_height = par_q[IDX_PADDLE_HEIGHT];
   assign bus.padding       = par_q[IDX_PADDING];
   assign bus.sel_idx       = sel_q;
   assign bus.edit_active   = edit_q;
   assign bus.param_changed = changed_q;
endmodule

// File: tb/tb_game_param_regs.sv
// tb_game_param_regs: directed and random stimulus against a behavioural model of game_param_regs
module tb_game_param_regs;
   localparam int W = 8, DLY = 4, RATE = 2;
   localparam int DEFS [4] = '{5, 10, 50, 16};
   localparam int MINS [4] = '{1, 2, 10, 0};
   localparam int MAXS [4] = '{15, 40, 120, 64};
   logic clk = 1'b0, rst_n = 1'b0;
   logic up = 1'b0, dn = 1'b0, sl = 1'b0, rd = 1'b0, gr = 1'b0;
   int   tests = 0, fails = 0;
   int   m_par [4];
   int   m_sel, m_edit, m_chg, m_act, m_age, m_locked;
   logic p_up, p_dn, p_sl;
   game_param_regs_if #(.WIDTH(W)) bus ();
   assign bus.btn_up           = up;
   assign bus.btn_down         = dn;
   assign bus.btn_sel          = sl;
   assign bus.restore_defaults = rd;
   assign bus.game_running     = gr;
   game_param_regs #(.WIDTH(W), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   // model: a press gives one step; with auto-repeat a press held for age edges
   // steps again at age DLY+1 and then every RATE edges
   task automatic model_edge();
      int old [4];
      int step_dir;
      step_dir = 0;
      old = m_par;
      if (!rst_n) begin
         m_par = DEFS; m_sel = 0; m_chg = 0; m_edit = 1; m_act = 0; m_age = 0; m_locked = 0;
         p_up = 0; p_dn = 0; p_sl = 0;
         return;
      end
      if (rd) m_par = DEFS;
      if (gr || rd) m_act = 0;
      else begin
         if (m_act != 0 && !(m_act == 1 ? up : dn)) m_act = 0;
         else if (m_act != 0) begin
            m_age++;
`ifdef PARAM_AUTOREPEAT_EN
            if (m_age > DLY && (m_age - 1 - DLY) % RATE == 0) step_dir = m_act;
`endif
         end else if (!m_locked && ((up && !p_up) != (dn && !p_dn))) begin
            m_act = (up && !p_up) ? 1 : 2;
            m_age = 1;
            step_dir = m_act;
         end
         if (step_dir == 1) m_par[m_sel] = m_par[m_sel] + 1 > MAXS[m_sel] ? MAXS[m_sel] : m_par[m_sel] + 1;
         if (step_dir == 2) m_par[m_sel] = m_par[m_sel] - 1 < MINS[m_sel] ? MINS[m_sel] : m_par[m_sel] - 1;
         if (sl && !p_sl && !up && !dn) m_sel = (m_sel + 1) % 4;
      end
      m_chg = (m_par != old) ? 1 : 0;
      m_edit = gr ? 0 : 1;
      m_locked = gr ? 1 : 0;
      p_up = up; p_dn = dn; p_sl = sl;
   endtask
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("ball_radius", 32'(bus.ball_radius), m_par[0]);
      chk("paddle_width", 32'(bus.paddle_width), m_par[1]);
      chk("paddle_height", 32'(bus.paddle_height), m_par[2]);
      chk("padding", 32'(bus.padding), m_par[3]);
      chk("sel_idx", 32'(bus.sel_idx), m_sel);
      chk("edit_active", 32'(bus.edit_active), m_edit);
      chk("param_changed", 32'(bus.param_changed), m_chg);
   endtask
   task automatic pulse(input int b, input int n);
      for (int k = 0; k < n; k++) begin
         if (b == 0) sl = 1; else if (b == 1) up = 1; else dn = 1;
         tick();
         sl = 0; up = 0; dn = 0;
         tick();
      end
   endtask
   initial begin
      tick();
      tick();
      chk("rst_ball", 32'(bus.ball_radius), 5);
      chk("rst_width", 32'(bus.paddle_width), 10);
      chk("rst_height", 32'(bus.paddle_height), 50);
      chk("rst_pad", 32'(bus.padding), 16);
      chk("rst_sel", 32'(bus.sel_idx), 0);
      chk("rst_chg", 32'(bus.param_changed), 0);
      rst_n = 1;
      tick();
      up = 1;
      tick();
      chk("inc_ball", 32'(bus.ball_radius), 6);
      chk("inc_pulse", 32'(bus.param_changed), 1);
      up = 0;
      tick();
      chk("inc_pulse_end", 32'(bus.param_changed), 0);
      pulse(0, 2);
      up = 1;
      tick();
      chk("hold_first", 32'(bus.paddle_height), 51);
      repeat (11) tick();
      up = 0;
      tick();
`ifdef PARAM_AUTOREPEAT_EN
      chk("hold_total", 32'(bus.paddle_height), 55);
`else
      chk("hold_total", 32'(bus.paddle_height), 51);
`endif
      pulse(0, 2);
      pulse(1, 12);
      chk("ball_max", 32'(bus.ball_radius), 15);
      up = 1;
      tick();
      chk("ball_sat", 32'(bus.ball_radius), 15);
      chk("ball_sat_chg", 32'(bus.param_changed), 0);
      up = 0;
      tick();
      pulse(0, 3);
      pulse(2, 20);
      chk("pad_min", 32'(bus.padding), 0);
      dn = 1;
      tick();
      chk("pad_sat", 32'(bus.padding), 0);
      chk("pad_sat_chg", 32'(bus.param_changed), 0);
      dn = 0;
      tick();
      for (int k = 1; k <= 4; k++) begin
         pulse(0, 1);
         chk("sel_wrap", 32'(bus.sel_idx), (3 + k) % 4);
      end
      up = 1;
      repeat (3) tick();
      gr = 1;
      repeat (8) tick();
      chk("lock_edit", 32'(bus.edit_active), 0);
      chk("lock_pad", 32'(bus.padding), m_par[3]);
      up = 0;
      gr = 0;
      repeat (2) tick();
      pulse(0, 2);
      pulse(1, 10);
      chk("width20", 32'(bus.paddle_width), 20);
      rd = 1;
      up = 1;
      tick();
      chk("restore_width", 32'(bus.paddle_width), 10);
      chk("restore_chg", 32'(bus.param_changed), 1);
      rd = 0;
      up = 0;
      tick();
      chk("restore_chg_end", 32'(bus.param_changed), 0);
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 5) == 0) up = ~up;
         if ($urandom_range(0, 5) == 0) dn = ~dn;
         if ($urandom_range(0, 4) == 0) sl = ~sl;
         if ($urandom_range(0, 40) == 0) gr = ~gr;
         rd = ($urandom_range(0, 60) == 0);
         rst_n = ($urandom_range(0, 250) != 0);
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
